// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: ID-stage register file with a per-register pending-write
// scoreboard. It provides NRD combinational read ports, one synchronous WB write
// port, and an issue port that reserves destination registers.
//
// Optional feature: define RF_BYPASS_EN to enable the write-through bypass. With
// it, a same-cycle WB write is visible on the read ports, and a final pending
// write counts as satisfied.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   rd_addr / rd_data   NRD packed read indices / read data (combinational)
//   rd_busy             per read port: the indexed register has a pending write
//   iss_en / iss_addr   reserve a destination register at issue
//   iss_full            combinational: the reservation counter of iss_addr is saturated
//   wr_en/addr/data     WB write port
//   sb_err              sticky: a write arrived for a register with no reservation
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_full,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    sb_err
);

    localparam int unsigned         NREG      = 2**ADDR_W;
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0]   ZERO_ADDR = '0;

    logic [DATA_W-1:0] mem     [NREG];
    logic [CNT_W-1:0]  cnt     [NREG];
    logic [CNT_W-1:0]  cnt_nxt [NREG];

    logic wr_live;
    logic iss_live;
    logic iss_take;
    logic iss_refused;
    logic underflow;

    // Register 0 is hard-wired: writes and issues to it are dropped here.
    assign wr_live     = wr_en  && (wr_addr  != ZERO_ADDR);
    assign iss_live    = iss_en && (iss_addr != ZERO_ADDR);
    assign iss_full    = !reset && (iss_addr != ZERO_ADDR) && (cnt[iss_addr] == CNT_MAX);
    assign iss_take    = iss_live && !iss_full;
    assign iss_refused = iss_live && iss_full;

    // A write paired with a same-cycle issue to that register is not an underflow.
    assign underflow = wr_live && (cnt[wr_addr] == '0) &&
                       !(iss_live && (iss_addr == wr_addr));

    // Next pending counts.
    // A refused issue freezes its register's count, even when a matching write occurs.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (iss_refused && (iss_addr == ADDR_W'(r))) begin
                cnt_nxt[r] = cnt[r];
            end else if (iss_take && (iss_addr == ADDR_W'(r))) begin
                if (!(wr_live && (wr_addr == ADDR_W'(r)))) begin
                    cnt_nxt[r] = cnt[r] + CNT_ONE;
                end
            end else if (wr_live && (wr_addr == ADDR_W'(r)) && (cnt[r] != '0)) begin
                cnt_nxt[r] = cnt[r] - CNT_ONE;
            end
        end
        cnt_nxt[0] = '0;
    end

    // Pending-count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    // Register array. mem[0] is never written, so it stays 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sticky underflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (underflow) begin
            sb_err <= 1'b1;
        end
    end

    // Combinational read ports. Each port works independently of the others.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign idx = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[idx];
            busy = (cnt[idx] != '0);
`ifdef RF_BYPASS_EN
            // A write-through from WB satisfies the last outstanding reservation.
            if (wr_live && (wr_addr == idx)) begin
                data = wr_data;
                busy = (cnt[idx] > CNT_ONE);
            end
`endif
            if (reset || (idx == ZERO_ADDR)) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p]                  = busy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NRD    = 2;
    localparam int unsigned CNT_W  = 2;

    logic                  clk;
    logic                  reset;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_full;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  sb_err;

    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;

    int checks = 0;
    int errors = 0;

    assign d0 = rd_data[DATA_W-1:0];
    assign d1 = rd_data[2*DATA_W-1:DATA_W];

    regfile_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(iss_full),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_en   = 1'b0;
        iss_addr = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        // Traffic while reset is held must be discarded and must not be visible.
        set_rd(5'd5, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd5;
        #1;
        checks++; if (d0 !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp %h", d0, 32'h0); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got %b exp %b", rd_busy, 2'b00); end
        checks++; if (iss_full !== 1'b0) begin errors++; $display("FAIL reset_iss_full got %b exp %b", iss_full, 1'b0); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %b exp %b", sb_err, 1'b0); end
        step();
        reset = 1'b0;
        idle();
        #1;
        checks++; if (d0 !== 32'h0) begin errors++; $display("FAIL reset_discard_wr got %h exp %h", d0, 32'h0); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL reset_discard_iss got %b exp %b", rd_busy[0], 1'b0); end
        // Register 0 ignores writes and issues.
        set_rd(5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        checks++; if (d0 !== 32'h0) begin errors++; $display("FAIL r0_same_cycle got %h exp %h", d0, 32'h0); end
        step();
        idle();
        #1;
        checks++; if (d0 !== 32'h0 || d1 !== 32'h0) begin errors++; $display("FAIL r0_read got %h %h exp 0 0", d0, d1); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL r0_busy got %b exp %b", rd_busy, 2'b00); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL r0_sb_err got %b exp %b", sb_err, 1'b0); end
        checks++; if (iss_full !== 1'b0) begin errors++; $display("FAIL r0_iss_full got %b exp %b", iss_full, 1'b0); end
    endtask

    task automatic test_basic();
        iss_en = 1'b1; iss_addr = 5'd5;
        step();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        step();
        idle();
        set_rd(5'd5, 5'd5);
        #1;
        checks++; if (d0 !== 32'h1234_5678) begin errors++; $display("FAIL basic_port0 got %h exp %h", d0, 32'h1234_5678); end
        checks++; if (d1 !== 32'h1234_5678) begin errors++; $display("FAIL basic_port1 got %h exp %h", d1, 32'h1234_5678); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL basic_busy got %b exp %b", rd_busy, 2'b00); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL basic_sb_err got %b exp %b", sb_err, 1'b0); end
    endtask

    task automatic test_raw();
        logic [DATA_W-1:0] exp_d;
        logic              exp_b;
        set_rd(5'd7, 5'd0);
        iss_en = 1'b1; iss_addr = 5'd7;
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL raw_busy_pre got %b exp %b", rd_busy[0], 1'b0); end
        step();
        idle();
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL raw_busy_after_iss got %b exp %b", rd_busy[0], 1'b1); end
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        #1;
`ifdef RF_BYPASS_EN
        exp_d = 32'hA5A5_A5A5; exp_b = 1'b0;
`else
        exp_d = 32'h0; exp_b = 1'b1;
`endif
        checks++; if (d0 !== exp_d) begin errors++; $display("FAIL raw_wr_cycle_data got %h exp %h", d0, exp_d); end
        checks++; if (rd_busy[0] !== exp_b) begin errors++; $display("FAIL raw_wr_cycle_busy got %b exp %b", rd_busy[0], exp_b); end
        step();
        idle();
        #1;
        checks++; if (d0 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL raw_after_data got %h exp %h", d0, 32'hA5A5_A5A5); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL raw_after_busy got %b exp %b", rd_busy[0], 1'b0); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL raw_sb_err got %b exp %b", sb_err, 1'b0); end
    endtask

    task automatic test_saturation();
        set_rd(5'd3, 5'd0);
        for (int k = 0; k < 3; k++) begin
            iss_en = 1'b1; iss_addr = 5'd3;
            step();
        end
        idle();
        iss_addr = 5'd3;
        #1;
        checks++; if (iss_full !== 1'b1) begin errors++; $display("FAIL sat_full got %b exp %b", iss_full, 1'b1); end
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sat_busy got %b exp %b", rd_busy[0], 1'b1); end
        // Fourth issue is refused.
        iss_en = 1'b1;
        step();
        iss_en = 1'b0;
        #1;
        checks++; if (iss_full !== 1'b1) begin errors++; $display("FAIL sat_refused got %b exp %b", iss_full, 1'b1); end
        // Issue and write to r3 together while saturated: refusal stands, count holds.
        iss_en = 1'b1; iss_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
        #1;
        checks++; if (iss_full !== 1'b1) begin errors++; $display("FAIL sat_same_cycle_full got %b exp %b", iss_full, 1'b1); end
        step();
        idle();
        iss_addr = 5'd3;
        #1;
        checks++; if (iss_full !== 1'b1) begin errors++; $display("FAIL sat_hold_3 got %b exp %b", iss_full, 1'b1); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_sb_err got %b exp %b", sb_err, 1'b0); end
        // Drain.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0031;
        step();
        wr_en = 1'b0;
        #1;
        checks++; if (iss_full !== 1'b0) begin errors++; $display("FAIL drain_not_full got %b exp %b", iss_full, 1'b0); end
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL drain_busy_2 got %b exp %b", rd_busy[0], 1'b1); end
        wr_en = 1'b1; wr_data = 32'h0000_0032;
        step();
        wr_data = 32'h0000_003C;
        step();
        idle();
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL drain_busy_0 got %b exp %b", rd_busy[0], 1'b0); end
        checks++; if (d0 !== 32'h0000_003C) begin errors++; $display("FAIL drain_data got %h exp %h", d0, 32'h0000_003C); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL drain_sb_err got %b exp %b", sb_err, 1'b0); end
    endtask

    task automatic test_underflow();
        set_rd(5'd9, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0001;
        #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL uflow_pre got %b exp %b", sb_err, 1'b0); end
        step();
        idle();
        #1;
        checks++; if (d0 !== 32'h0000_0001) begin errors++; $display("FAIL uflow_data got %h exp %h", d0, 32'h0000_0001); end
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uflow_sb_err got %b exp %b", sb_err, 1'b1); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL uflow_busy got %b exp %b", rd_busy[0], 1'b0); end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uflow_sticky_%0d got %b exp %b", k, sb_err, 1'b1); end
        end
    endtask

    task automatic test_reset_mid();
        set_rd(5'd6, 5'd4);
        iss_en = 1'b1; iss_addr = 5'd4;
        step();
        iss_addr = 5'd6;
        step();
        idle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0055;
        step();
        idle();
        #1;
        checks++; if (rd_busy !== 2'b01) begin errors++; $display("FAIL mid_pre_busy got %b exp %b", rd_busy, 2'b01); end
        checks++; if (d1 !== 32'h0000_0055) begin errors++; $display("FAIL mid_pre_data got %h exp %h", d1, 32'h0000_0055); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL mid_async_data got %h exp %h", d1, 32'h0); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL mid_async_busy got %b exp %b", rd_busy, 2'b00); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL mid_async_sb_err got %b exp %b", sb_err, 1'b0); end
        #2;
        reset = 1'b0;
        step();
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h0000_0066;
        #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL mid_wr_pre got %b exp %b", sb_err, 1'b0); end
        step();
        idle();
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL mid_wr_sb_err got %b exp %b", sb_err, 1'b1); end
        checks++; if (d0 !== 32'h0000_0066) begin errors++; $display("FAIL mid_wr_data got %h exp %h", d0, 32'h0000_0066); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL mid_wr_busy got %b exp %b", rd_busy[0], 1'b0); end
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0;
        idle();
        test_reset();
        test_basic();
        test_raw();
        test_saturation();
        test_underflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
